// File: rtl/affinex_pkg.sv
// affinex_pkg: shared widths and saturation limits for the affine datapath
package affinex_pkg;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_FRAC  = 8;
    localparam int ACC_W     = 2*DEF_WIDTH+2;
    function automatic longint sat_max(int w);
        return (longint'(1) <<< (w-1)) - 1;
    endfunction
    function automatic longint sat_min(int w);
        return -(longint'(1) <<< (w-1));
    endfunction
    localparam longint SAT_MAX = sat_max(DEF_WIDTH);
    localparam longint SAT_MIN = sat_min(DEF_WIDTH);
endpackage

// File: rtl/affine_accum_sat_round.sv
// sat_round: round half up, rescale by FRAC and clip a wide total to WIDTH bits
module sat_round
    import affinex_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int FRAC  = DEF_FRAC
) (
    input  logic [2*WIDTH+1:0] i_total,
    output logic [WIDTH-1:0]   o_result,
    output logic               o_clip
);
    localparam int AW = 2*WIDTH+2;
    localparam logic signed [AW-1:0] HALF = (FRAC > 0) ? AW'(longint'(1) <<< (FRAC > 0 ? FRAC-1 : 0)) : '0;
    localparam logic signed [AW-1:0] MAXV = AW'(sat_max(WIDTH));
    localparam logic signed [AW-1:0] MINV = AW'(sat_min(WIDTH));
    logic signed [AW-1:0] w_shift;
    logic                 w_hi;
    logic                 w_lo;
    assign w_shift  = ($signed(i_total) + HALF) >>> FRAC;
    assign w_hi     = w_shift > MAXV;
    assign w_lo     = w_shift < MINV;
    assign o_clip   = w_hi || w_lo;
    assign o_result = w_hi ? MAXV[WIDTH-1:0] : w_lo ? MINV[WIDTH-1:0] : w_shift[WIDTH-1:0];
endmodule

// File: rtl/affine_accum.sv
// affine_accum: sums TERMS products plus offset, rounds/saturates, emits via valid/ready
module affine_accum
    import affinex_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int FRAC  = DEF_FRAC,
    parameter int TERMS = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clear,
    input  logic [2*WIDTH-1:0] i_prod,
    input  logic               i_prod_valid,
    input  logic [WIDTH-1:0]   i_offset,
    output logic               o_accept,
    output logic [WIDTH-1:0]   o_out,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic               o_busy,
    output logic               o_sat,
    output logic               o_err
);
    localparam int AW = 2*WIDTH+2;
    localparam int CW = (TERMS > 1) ? $clog2(TERMS) : 1;
    localparam logic [CW-1:0] LAST = CW'(TERMS-1);
    logic signed [AW-1:0] r_acc;
    logic signed [AW-1:0] w_prod;
    logic signed [AW-1:0] w_total;
    logic [CW-1:0]        r_count;
    logic [WIDTH-1:0]     r_out;
    logic [WIDTH-1:0]     w_res;
    logic                 r_out_valid;
    logic                 r_sat;
    logic                 r_err;
    logic                 w_clip;
    logic                 w_last;
    logic                 w_take;
    assign w_last      = r_count == LAST;
    // only a final product needs the output register, so only it can be refused
    assign o_accept    = !(r_out_valid && !i_out_ready && w_last);
    assign w_take      = i_prod_valid && o_accept;
    assign w_prod      = AW'($signed(i_prod));
    assign w_total     = r_acc + w_prod + (AW'($signed(i_offset)) <<< FRAC);
    assign o_out       = r_out;
    assign o_out_valid = r_out_valid;
    assign o_busy      = r_count != '0;
    assign o_sat       = r_sat;
    assign o_err       = r_err;
    sat_round #(.WIDTH(WIDTH), .FRAC(FRAC)) u_sat (
        .i_total  (w_total),
        .o_result (w_res),
        .o_clip   (w_clip)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_count     <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_sat       <= 1'b0;
            r_err       <= 1'b0;
        end else if (i_clear) begin
            r_acc       <= '0;
            r_count     <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_sat       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (r_out_valid && i_out_ready) r_out_valid <= 1'b0;
            if (i_prod_valid && !o_accept) r_err <= 1'b1;
            if (w_take && w_last) begin
                r_out       <= w_res;
                r_out_valid <= 1'b1;
                r_sat       <= r_sat || w_clip;
                r_acc       <= '0;
                r_count     <= '0;
            end else if (w_take) begin
                r_acc   <= r_acc + w_prod;
                r_count <= r_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_affine_accum.sv
// tb_affine_accum: directed vectors against a queue-based arithmetic model
module tb_affine_accum;
    localparam int TERMS = 2;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clear = 1'b0;
    logic [31:0] prod = '0;
    logic        pv = 1'b0;
    logic [15:0] off = '0;
    logic        rdy = 1'b1;
    logic        accept, out_valid, busy, sat, err;
    logic [15:0] out;
    int          total = 0;
    int          bad = 0;
    bit          run = 1'b0;
    longint      grp[$];
    logic [15:0] m_out = '0;
    bit          m_valid = 1'b0;
    bit          m_sat = 1'b0;
    bit          m_err = 1'b0;

    affine_accum #(.WIDTH(16), .FRAC(8), .TERMS(TERMS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (clear),
        .i_prod       (prod),
        .i_prod_valid (pv),
        .i_offset     (off),
        .o_accept     (accept),
        .o_out        (out),
        .o_out_valid  (out_valid),
        .i_out_ready  (rdy),
        .o_busy       (busy),
        .o_sat        (sat),
        .o_err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, longint act, longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        grp.delete();
        m_valid = 1'b0;
        m_out   = '0;
        m_sat   = 1'b0;
        m_err   = 1'b0;
    endtask

    // group sum + offset, rounded half up and scaled down by 2^8, clipped to int16
    task automatic model_update();
        bit     ok;
        longint sum;
        longint q;
        if (clear) begin
            model_reset();
        end else begin
            ok = !(m_valid && !rdy && grp.size() == TERMS-1);
            if (m_valid && rdy) m_valid = 1'b0;
            if (pv && !ok) m_err = 1'b1;
            else if (pv) begin
                grp.push_back(longint'($signed(prod)));
                if (grp.size() == TERMS) begin
                    sum = longint'($signed(off)) * 256 + 128;
                    foreach (grp[k]) sum += grp[k];
                    q = sum >>> 8;
                    if (q > 32767) begin q = 32767; m_sat = 1'b1; end
                    else if (q < -32768) begin q = -32768; m_sat = 1'b1; end
                    m_out   = q[15:0];
                    m_valid = 1'b1;
                    grp.delete();
                end
            end
        end
    endtask

    task automatic step(bit v, logic [31:0] p, logic [15:0] o, bit r, bit c);
        pv = v; prod = p; off = o; rdy = r; clear = c;
        @(posedge clk); #1;
        model_update();
    endtask

    task automatic do_reset();
        pv = 1'b0; clear = 1'b0; rdy = 1'b1;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk); #1;
        chk("rst_out", out, 16'h0000);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sat", sat, 0);
        chk("rst_err", err, 0);
        chk("rst_accept", accept, 1);
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (run) begin
            chk("valid", out_valid, m_valid);
            if (m_valid) chk("out", out, m_out);
            chk("busy", busy, grp.size() != 0);
            chk("sat", sat, m_sat);
            chk("err", err, m_err);
            chk("accept", accept, !(m_valid && !rdy && grp.size() == TERMS-1));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        run = 1'b1;
        chk("init_valid", out_valid, 0);
        chk("init_accept", accept, 1);
        // basic
        step(1, 32'h0003_0000, 16'h0000, 1, 0);
        chk("basic_busy", busy, 1);
        step(1, 32'h0001_8000, 16'h0080, 1, 0);
        chk("basic_out", out, 16'h0500);
        chk("basic_model", m_out, 16'h0500);
        chk("basic_valid", out_valid, 1);
        chk("basic_sat", sat, 0);
        // rounding
        step(1, 32'h0000_0080, 16'h0000, 1, 0);
        step(1, 32'h0000_0000, 16'h0000, 1, 0);
        chk("round_up", out, 16'h0001);
        step(1, 32'hFFFF_FF80, 16'h0000, 1, 0);
        step(1, 32'h0000_0000, 16'h0000, 1, 0);
        chk("round_neg", out, 16'h0000);
        chk("round_model", m_out, 16'h0000);
        // saturation
        step(1, 32'h7F00_0000, 16'h0000, 1, 0);
        step(1, 32'h7F00_0000, 16'h0000, 1, 0);
        chk("sat_pos", out, 16'h7FFF);
        chk("sat_pos_flag", sat, 1);
        chk("sat_model", m_out, 16'h7FFF);
        step(0, 32'h0, 16'h0000, 1, 1);
        chk("clear_sat", sat, 0);
        step(1, 32'h8000_0000, 16'h0000, 1, 0);
        step(1, 32'h8000_0000, 16'h0000, 1, 0);
        chk("sat_neg", out, 16'h8000);
        chk("sat_neg_flag", sat, 1);
        step(0, 32'h0, 16'h0000, 1, 1);
        // backpressure
        step(1, 32'h0000_0100, 16'h0000, 0, 0);
        step(1, 32'h0000_0100, 16'h0000, 0, 0);
        chk("bp_held", out, 16'h0002);
        step(1, 32'h0000_0300, 16'h0000, 0, 0);
        chk("bp_first_busy", busy, 1);
        chk("bp_accept_low", accept, 0);
        step(1, 32'h0000_0500, 16'h0000, 0, 0);
        chk("bp_err", err, 1);
        chk("bp_out_kept", out, 16'h0002);
        step(0, 32'h0, 16'h0000, 1, 0);
        chk("bp_popped", out_valid, 0);
        step(1, 32'h0000_0500, 16'h0000, 1, 0);
        chk("bp_final", out, 16'h0008);
        step(0, 32'h0, 16'h0000, 1, 1);
        // simultaneous pop and final load
        step(1, 32'h0000_0100, 16'h0000, 0, 0);
        step(1, 32'h0000_0100, 16'h0000, 0, 0);
        step(1, 32'h0000_0200, 16'h0000, 0, 0);
        step(1, 32'h0000_0400, 16'h0000, 1, 0);
        chk("sim_valid", out_valid, 1);
        chk("sim_out", out, 16'h0006);
        chk("sim_err", err, 0);
        step(0, 32'h0, 16'h0000, 1, 0);
        // reset mid-group
        step(1, 32'h0000_1000, 16'h0000, 1, 0);
        do_reset();
        step(1, 32'h0000_0200, 16'h0000, 1, 0);
        step(1, 32'h0000_0200, 16'h0001, 1, 0);
        chk("rst_grp_out", out, 16'h0005);
        // clear mid-group, with a product dropped by the clear
        step(1, 32'h0000_1000, 16'h0000, 1, 0);
        step(1, 32'h0000_1000, 16'h0000, 1, 1);
        chk("clr_busy", busy, 0);
        chk("clr_err", err, 0);
        chk("clr_valid", out_valid, 0);
        step(1, 32'h0000_0200, 16'h0000, 1, 0);
        step(1, 32'h0000_0200, 16'h0001, 1, 0);
        chk("clr_grp_out", out, 16'h0005);
        step(0, 32'h0, 16'h0000, 1, 0);
        step(0, 32'h0, 16'h0000, 1, 0);
        @(posedge clk);
        run = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/affine_accum.md
# affine_accum

Downstream consumer of the sequential signed multiplier in the affine datapath. Accumulates TERMS consecutive fixed-point products, adds a translation offset, rounds and rescales to the operand format, saturates, and presents one output coordinate per group through a valid/ready handshake. Example: x' = a·x + b·y + tx. The block back-pressures the multiplier sequencer via accept_o, because the multiplier's done pulse cannot be stalled.

## Interface
- WIDTH, 16, operand/output width; products are 2·WIDTH
- FRAC, 8, fractional bits of operands/output (0 ≤ FRAC < WIDTH)
- TERMS, 2, products per output group (1..4)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- clear_i  in  1  synchronous flush of accumulator, count, output and sticky flags
- prod_i  in  2·WIDTH  signed product (multiplier result)
- prod_valid_i  in  1  one-cycle pulse, prod_i valid (multiplier done)
- offset_i  in  WIDTH  signed translation, same Q format as output; sampled with the final product
- accept_o  out  1  a prod_valid_i this cycle is accepted
- out_o  out  WIDTH  signed result
- out_valid_o  out  1  out_o valid
- out_ready_i  in  1  consumer accepts out_o
- busy_o  out  1  group partially accumulated (count ≠ 0)
- sat_o  out  1  sticky, a result was saturated
- err_o  out  1  sticky, a product arrived while accept_o was low and was dropped

## Operation
- Accumulator: signed, 2·WIDTH+2 bits. count ranges 0..TERMS-1.
- Non-final accepted product (count < TERMS-1): acc += sign-extended prod_i; count++.
- Final accepted product: total = acc + prod_i + (offset_i <<< FRAC) + (FRAC>0 ? 2^(FRAC-1) : 0).
  - Round half up.
  - Arithmetic shift right by FRAC.
  - Saturate to [−2^(WIDTH-1), 2^(WIDTH-1)−1]; set sat_o if clipped.
  - Load out_o; set out_valid_o; clear acc and count.
- accept_o = !(out_valid_o && !out_ready_i && count == TERMS-1). This is combinational from out_ready_i.
  - Non-final products are always accepted, including while the output is held.
- Dropped product (prod_valid_i && !accept_o): acc, count and out_o unchanged; err_o set.
- Output handshake:
  - out_valid_o && out_ready_i pops the output; out_valid_o falls next edge unless a new final result loads in the same cycle.
  - Pop and final-product load in the same cycle: out_valid_o stays 1 and out_o takes the new value.
- out_o is stable while out_valid_o && !out_ready_i.
- Priority: clear_i > product handling. clear_i drops any product presented in the same cycle without setting err_o.
- Reset mid-group: everything returns to reset state; the partial group is lost.

## Timing
- Reset values: out_o 0, out_valid_o 0, busy_o 0, sat_o 0, err_o 0. accept_o 1 (combinational from reset state).
- Latency: out_valid_o rises on the edge that samples the final prod_valid_i; result is visible the next cycle.
- Throughput: one product per cycle sustained; one group per TERMS products.
- busy_o rises the cycle after the first accepted product of a group and falls the cycle after the final one.
- Sticky flags clear only on reset or clear_i.

## Structure
- Package affinex_pkg holds:
  - default WIDTH/FRAC constants
  - ACC_W = 2·WIDTH+2 localparam
  - shared min/max saturation constants
- Sub-module sat_round (combinational): inputs total (ACC_W), parameters FRAC and WIDTH; outputs the WIDTH-bit result and a clip flag.
- Top level holds count, acc, output register and sticky flags. No explicit FSM beyond count and out_valid.

## Test plan
All cases use WIDTH=16, FRAC=8, TERMS=2.
- Basic: prods 0x00030000, 0x00018000, offset 0x0080 → out_o 0x0500 one cycle later, out_valid_o 1, sat_o 0.
- Rounding: prods 0x00000080, 0, offset 0 → 0x0001. Prods 0xFFFFFF80, 0 → 0x0000.
- Saturation: prods 0x7F000000 ×2 → 0x7FFF, sat_o 1. After clear_i, prods 0x80000000 ×2 → 0x8000, sat_o 1.
- Backpressure: out_ready_i 0 with a result held.
  - Next first product → accepted, busy_o 1.
  - accept_o then 0; final product pulsed → err_o 1, out_o unchanged.
  - Raise ready → pop; following final product accepted.
- Simultaneous pop and final product in the same cycle → no drop, out_valid_o stays 1, out_o takes the new value.
- Reset and clear mid-group:
  - After one product, assert rst_n low → all outputs at reset values.
  - Next two products produce a correct result with no residue from the lost group.
  - Repeat the same sequence using clear_i instead of reset.
